// File: rtl/acc_share_arbiter.sv
// Two-requester round-robin front end for a shared signed add/subtract accumulator.
// Each grant runs IDLE -> EXEC -> ACK. EXEC updates S/OF and raises the winner's Ack.
module acc_share_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Resetn,
   input  logic             Req0,
   input  logic             Mode0,
   input  logic [WIDTH-1:0] A0,
   input  logic             Req1,
   input  logic             Mode1,
   input  logic [WIDTH-1:0] A1,
   input  logic             Clear,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Busy,
   output logic [WIDTH-1:0] S,
   output logic             OF
);

   typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] s_reg, s_next;
   logic             of_reg, of_next;
   logic             ack0_reg, ack0_next;
   logic             ack1_reg, ack1_next;
   logic             busy_reg, busy_next;
   logic             ptr_reg, ptr_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic             mode_reg, mode_next;
   logic             id_reg, id_next;

   logic             win1;
   logic [WIDTH:0]   s_ext, a_ext, sum_ext;

   // One extra sign bit: overflow shows up as a disagreement between the top two bits.
   assign s_ext   = {s_reg[WIDTH-1], s_reg};
   assign a_ext   = {a_reg[WIDTH-1], a_reg};
   assign sum_ext = mode_reg ? (s_ext - a_ext) : (s_ext + a_ext);

   // With both requests up, the pointer names the winner.
   assign win1 = Req1 && (!Req0 || ptr_reg);

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      of_next    = of_reg;
      ack0_next  = ack0_reg;
      ack1_next  = ack1_reg;
      busy_next  = busy_reg;
      ptr_next   = ptr_reg;
      a_next     = a_reg;
      mode_next  = mode_reg;
      id_next    = id_reg;
      case (state_reg)
         IDLE: begin
            if (Clear) begin
               s_next  = '0;
               of_next = 1'b0;
            end else if (Req0 || Req1) begin
               id_next    = win1;
               a_next     = win1 ? A1 : A0;
               mode_next  = win1 ? Mode1 : Mode0;
               busy_next  = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            s_next     = sum_ext[WIDTH-1:0];
            of_next    = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
            ack0_next  = !id_reg;
            ack1_next  = id_reg;
            state_next = ACK;
         end
         ACK: begin
            ack0_next  = 1'b0;
            ack1_next  = 1'b0;
            busy_next  = 1'b0;
            ptr_next   = !id_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         of_reg    <= 1'b0;
         ack0_reg  <= 1'b0;
         ack1_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         ptr_reg   <= 1'b0;
         a_reg     <= '0;
         mode_reg  <= 1'b0;
         id_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         of_reg    <= of_next;
         ack0_reg  <= ack0_next;
         ack1_reg  <= ack1_next;
         busy_reg  <= busy_next;
         ptr_reg   <= ptr_next;
         a_reg     <= a_next;
         mode_reg  <= mode_next;
         id_reg    <= id_next;
      end
   end

   assign Ack0 = ack0_reg;
   assign Ack1 = ack1_reg;
   assign Busy = busy_reg;
   assign S    = s_reg;
   assign OF   = of_reg;

endmodule

// File: tb/tb_acc_share_arbiter.sv
// Directed bench for acc_share_arbiter with hand-computed expected values.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_acc_share_arbiter;

   logic       Clk = 1'b0;
   logic       Resetn, Req0, Mode0, Req1, Mode1, Clear;
   logic [7:0] A0, A1;
   logic       Ack0, Ack1, Busy, OF;
   logic [7:0] S;

   int vectors    = 0;
   int miscompares = 0;

   acc_share_arbiter #(.WIDTH(8)) dut (
      .Clk(Clk), .Resetn(Resetn),
      .Req0(Req0), .Mode0(Mode0), .A0(A0),
      .Req1(Req1), .Mode1(Mode1), .A1(A1),
      .Clear(Clear),
      .Ack0(Ack0), .Ack1(Ack1), .Busy(Busy), .S(S), .OF(OF)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
   endtask

   // Requests already driven, FSM in IDLE: grant, EXEC, ACK.
   task automatic serve(input string tag, input logic id, input logic [7:0] exp_s, input logic exp_of);
      step();
      check({tag, " busy_grant"}, {7'd0, Busy}, 8'd1);
      check({tag, " noack_grant"}, {6'd0, Ack1, Ack0}, 8'd0);
      step();
      check({tag, " S"}, S, exp_s);
      check({tag, " OF"}, {7'd0, OF}, {7'd0, exp_of});
      check({tag, " ack"}, {6'd0, Ack1, Ack0}, id ? 8'd2 : 8'd1);
      if (id) Req1 = 1'b0; else Req0 = 1'b0;
      step();
      check({tag, " ack_low"}, {6'd0, Ack1, Ack0}, 8'd0);
      check({tag, " busy_low"}, {7'd0, Busy}, 8'd0);
   endtask

   task automatic req0(input logic m, input logic [7:0] a);
      Req0 = 1'b1; Mode0 = m; A0 = a;
   endtask

   task automatic req1(input logic m, input logic [7:0] a);
      Req1 = 1'b1; Mode1 = m; A1 = a;
   endtask

   logic [7:0] arb_s [5] = '{8'h01, 8'h11, 8'h12, 8'h22, 8'h23};

   initial begin
      Resetn = 1'b0; Req0 = 1'b1; Mode0 = 1'b0; A0 = 8'h33;
      Req1 = 1'b0; Mode1 = 1'b0; A1 = 8'h00; Clear = 1'b0;
      step();
      step();
      check("reset S", S, 8'h00);
      check("reset OF", {7'd0, OF}, 8'd0);
      check("reset acks", {6'd0, Ack1, Ack0}, 8'd0);
      check("reset busy", {7'd0, Busy}, 8'd0);
      Resetn = 1'b1; Req0 = 1'b0;

      req0(1'b0, 8'h05); serve("r0 add05", 1'b0, 8'h05, 1'b0);
      req1(1'b1, 8'h03); serve("r1 sub03", 1'b1, 8'h02, 1'b0);
      req0(1'b0, 8'h7D); serve("add7D", 1'b0, 8'h7F, 1'b0);
      req0(1'b0, 8'h01); serve("7F+01", 1'b0, 8'h80, 1'b1);
      req0(1'b0, 8'h01); serve("80+01", 1'b0, 8'h81, 1'b0);
      req0(1'b1, 8'h01); serve("81-01", 1'b0, 8'h80, 1'b0);
      req0(1'b1, 8'h01); serve("80-01", 1'b0, 8'h7F, 1'b1);
      req0(1'b1, 8'h3D); serve("7F-3D", 1'b0, 8'h42, 1'b0);

      // Clear in IDLE beats a pending request; the request is granted next edge.
      req0(1'b0, 8'h03); Clear = 1'b1;
      step();
      check("clear S", S, 8'h00);
      check("clear OF", {7'd0, OF}, 8'd0);
      check("clear nogrant", {7'd0, Busy}, 8'd0);
      Clear = 1'b0;
      serve("after clear", 1'b0, 8'h03, 1'b0);

      // Clear held through EXEC and ACK is ignored.
      req1(1'b0, 8'h10);
      step();
      check("clrexec busy", {7'd0, Busy}, 8'd1);
      Clear = 1'b1;
      step();
      check("clrexec S", S, 8'h13);
      check("clrexec ack1", {6'd0, Ack1, Ack0}, 8'd2);
      Req1 = 1'b0;
      step();
      check("clrexec S hold", S, 8'h13);
      Clear = 1'b0;

      // Arbitration starts from pointer 0 after reset, then strictly alternates.
      Resetn = 1'b0;
      step();
      Resetn = 1'b1;
      req0(1'b0, 8'h01); req1(1'b0, 8'h10);
      for (int i = 0; i < 5; i++) begin
         serve($sformatf("arb%0d", i), logic'(i % 2), arb_s[i], 1'b0);
         if (i % 2 == 1) Req1 = 1'b1; else if (i < 4) Req0 = 1'b1;
      end

      // Pointer is now 1 and Req1 is pending: abort it with reset in EXEC.
      step();
      check("midrst busy", {7'd0, Busy}, 8'd1);
      Resetn = 1'b0; Req1 = 1'b0;
      step();
      check("midrst S", S, 8'h00);
      check("midrst acks", {6'd0, Ack1, Ack0}, 8'd0);
      check("midrst busy low", {7'd0, Busy}, 8'd0);
      Resetn = 1'b1;
      step();
      check("midrst no late ack", {6'd0, Ack1, Ack0}, 8'd0);
      check("midrst S hold", S, 8'h00);
      req0(1'b0, 8'h07); req1(1'b0, 8'h20);
      serve("post rst ptr0", 1'b0, 8'h07, 1'b0);
      serve("post rst r1", 1'b1, 8'h27, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
